// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-pin output block with a shared 8-bit PWM generator.
// Each pin is either a static enable or the common PWM waveform gated by its enable.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned PRE_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned N_OUT = 16;

    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] DUTY_FULL = '1;

    logic [PRE_W-1:0] prescaler;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_active;

    logic [N_OUT-1:0] en_out_c;
    logic [N_OUT-1:0] en_pwm_c;
    logic [N_OUT-1:0] out_next_c;
    logic             tick_c;
    logic             wrap_c;
    logic             pwm_sig_c;

    // Step/wrap decode, waveform compare and per-pin output mux
    always_comb begin
        en_out_c   = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm_c   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        tick_c     = (prescaler == PRE_MAX);
        wrap_c     = tick_c && (pwm_cnt == CNT_MAX);
        // Full-scale duty is forced high so the last count of the period never drops
        pwm_sig_c  = (duty_active == DUTY_FULL) ? 1'b1 : (pwm_cnt < duty_active);
        out_next_c = en_out_c & (~en_pwm_c | {N_OUT{pwm_sig_c}});
    end

    // Prescaler: counts 0..CLK_DIV-1, one PWM step per wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick_c) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // PWM position counter, natural 8-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick_c) begin
            pwm_cnt <= pwm_cnt + CNT_W'(1);
        end
    end

    // Duty shadow: requested duty is sampled only at the period boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
        end else if (wrap_c) begin
            duty_active <= pwm_duty_cycle;
        end
    end

    // Registered pins and period-start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= out_next_c;
            period_start <= wrap_c;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboard bench for pwm_peripheral at CLK_DIV=12 and CLK_DIV=1.
// Stimulus pushes per-period expectations; monitors measure each period between
// period_start pulses and compare against the queue.
module tb_pwm_peripheral;

    typedef struct {
        int unsigned len;
        int unsigned high;
        logic [14:0] rest;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rst1_n;
    logic [15:0] en_out0, en_pwm0, en_out1, en_pwm1;
    logic [7:0]  duty0, duty1;
    logic [15:0] out0, out1;
    logic        ps0, ps1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int unsigned w0_len, w0_high, w1_len, w1_high;
    logic [14:0] w0_rest, w1_rest;
    bit          w0_on = 1'b0;
    bit          w1_on = 1'b0;

    pwm_peripheral #(.CLK_DIV(12)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out0[7:0]),
        .en_reg_out_15_8 (en_out0[15:8]),
        .en_reg_pwm_7_0  (en_pwm0[7:0]),
        .en_reg_pwm_15_8 (en_pwm0[15:8]),
        .pwm_duty_cycle  (duty0),
        .out             (out0),
        .period_start    (ps0)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst1_n),
        .en_reg_out_7_0  (en_out1[7:0]),
        .en_reg_out_15_8 (en_out1[15:8]),
        .en_reg_pwm_7_0  (en_pwm1[7:0]),
        .en_reg_pwm_15_8 (en_pwm1[15:8]),
        .pwm_duty_cycle  (duty1),
        .out             (out1),
        .period_start    (ps1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for the next period_start of the selected instance, counting cycles and
    // cycles in which any output pin was high. Bounded at 4000 cycles.
    task automatic wait_ps(input bit sel, output int cycles, output int highs);
        cycles = 0;
        highs  = 0;
        do begin
            @(negedge clk);
            cycles++;
            if ((sel ? out1 : out0) != 16'h0) highs++;
        end while (!(sel ? ps1 : ps0) && cycles < 4000);
    endtask

    task automatic push0(input int unsigned len, input int unsigned high);
        q0.push_back('{len: len, high: high, rest: 15'h0});
    endtask

    task automatic push1(input int unsigned len, input int unsigned high);
        q1.push_back('{len: len, high: high, rest: 15'h0});
    endtask

    // Monitor for the CLK_DIV=12 instance: one window per PWM period
    always @(negedge clk) begin
        if (!rst_n) begin
            w0_on = 1'b0;
        end else begin
            if (ps0) begin
                if (w0_on && q0.size() > 0) begin
                    e0 = q0.pop_front();
                    chk("div12_period_len", w0_len, e0.len);
                    chk("div12_high_time", w0_high, e0.high);
                    chk("div12_other_pins", 32'(w0_rest), 32'(e0.rest));
                end
                w0_on   = 1'b1;
                w0_len  = 0;
                w0_high = 0;
                w0_rest = '0;
            end
            if (w0_on) begin
                w0_len++;
                if (out0[0]) w0_high++;
                w0_rest = w0_rest | out0[15:1];
            end
        end
    end

    // Monitor for the CLK_DIV=1 instance
    always @(negedge clk) begin
        if (!rst1_n) begin
            w1_on = 1'b0;
        end else begin
            if (ps1) begin
                if (w1_on && q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("div1_period_len", w1_len, e1.len);
                    chk("div1_high_time", w1_high, e1.high);
                    chk("div1_other_pins", 32'(w1_rest), 32'(e1.rest));
                end
                w1_on   = 1'b1;
                w1_len  = 0;
                w1_high = 0;
                w1_rest = '0;
            end
            if (w1_on) begin
                w1_len++;
                if (out1[0]) w1_high++;
                w1_rest = w1_rest | out1[15:1];
            end
        end
    end

    task automatic stim_div12();
        int cyc, hi, cnt;
        rst_n   = 1'b0;
        en_out0 = 16'h0001;
        en_pwm0 = 16'h0001;
        duty0   = 8'h80;
        repeat (3) @(negedge clk);
        chk("reset_out", 32'(out0), 32'h0);
        chk("reset_period_start", 32'(ps0), 32'h0);
        rst_n = 1'b1;

        wait_ps(1'b0, cyc, hi);
        chk("first_ps_delay", cyc, 3072);
        chk("first_period_low", hi, 0);
        push0(3072, 1536);
        duty0 = 8'h00;

        wait_ps(1'b0, cyc, hi);
        chk("period_len_a", cyc, 3072);
        push0(3072, 0);
        duty0 = 8'h40;

        wait_ps(1'b0, cyc, hi);
        chk("period_len_b", cyc, 3072);
        push0(3072, 768);
        repeat (1200) @(negedge clk);
        duty0 = 8'hC0;

        wait_ps(1'b0, cyc, hi);
        push0(3072, 2304);
        duty0 = 8'hFF;

        wait_ps(1'b0, cyc, hi);
        chk("period_len_c", cyc, 3072);
        push0(3072, 3071);

        wait_ps(1'b0, cyc, hi);
        push0(3072, 3072);

        wait_ps(1'b0, cyc, hi);
        push0(3072, 3072);
        duty0 = 8'h80;

        wait_ps(1'b0, cyc, hi);
        @(negedge clk);
        chk("div12_queue_drained", q0.size(), 0);

        en_pwm0 = 16'h0000;
        en_out0 = 16'hFFFF;
        @(negedge clk);
        chk("static_latency", 32'(out0), 32'hFFFF);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out0 !== 16'hFFFF) cnt++;
        end
        chk("static_hold", cnt, 0);
        en_out0 = 16'hFFF7;
        @(negedge clk);
        chk("clear_bit3", 32'(out0), 32'hFFF7);

        en_out0 = 16'h0F0F;
        en_pwm0 = 16'hF0F0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out0 !== 16'h0F0F) cnt++;
        end
        chk("disabled_pins_low", cnt, 0);

        en_out0 = 16'hFFFF;
        en_pwm0 = 16'h0000;
        wait_ps(1'b0, cyc, hi);
        repeat (2400) @(negedge clk);
        chk("pre_reset_out", 32'(out0), 32'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out", 32'(out0), 32'h0);
        chk("async_reset_ps", 32'(ps0), 32'h0);
        en_pwm0 = 16'hFFFF;
        duty0   = 8'h80;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps(1'b0, cyc, hi);
        chk("restart_ps_delay", cyc, 3072);
        chk("restart_first_period_low", hi, 0);
        @(negedge clk);
        chk("restart_first_high", 32'(out0), 32'hFFFF);
    endtask

    task automatic stim_div1();
        int cyc, hi;
        rst1_n  = 1'b0;
        en_out1 = 16'h0001;
        en_pwm1 = 16'h0001;
        duty1   = 8'h01;
        repeat (2) @(negedge clk);
        chk("div1_reset_out", 32'(out1), 32'h0);
        rst1_n = 1'b1;
        wait_ps(1'b1, cyc, hi);
        chk("div1_first_ps_delay", cyc, 256);
        chk("div1_first_period_low", hi, 0);
        push1(256, 1);
        for (int i = 0; i < 4; i++) begin
            wait_ps(1'b1, cyc, hi);
            chk("div1_ps_spacing", cyc, 256);
            if (i < 3) push1(256, 1);
        end
        @(negedge clk);
        chk("div1_queue_drained", q1.size(), 0);
    endtask

    initial begin
        fork
            stim_div12();
            stim_div1();
        join
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
